capture_ram_reader: RTL and testbench
=====================================

CAPTURE_RAM_READER -- requirements
Module: capture_ram_reader

Interface
REQ-001 Parameter ROW_WIDTH, default 320, SHALL set pixels per row and the RAM word width.
REQ-002 Parameter ADDR_WIDTH, default 8, SHALL set the row index and RAM address width.
REQ-003 Parameter RAM_LATENCY, default 1, SHALL set the clocks from read_enable to valid ram_q; the legal range SHALL be 1..3.
REQ-004 The block SHALL have one clock and a synchronous, active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  synchronous active-low reset.
REQ-005 row_request  in  1  single-cycle start pulse for one row readout.
REQ-006 row_index  in  ADDR_WIDTH  row to read, sampled with row_request.
REQ-007 ram_q  in  ROW_WIDTH  RAM read data.
REQ-008 pixel_ready  in  1  downstream accepts pixel this cycle.
REQ-009 ram_address  out  ADDR_WIDTH  RAM read address.
REQ-010 read_enable  out  1  RAM read strobe.
REQ-011 pixel  out  1  current pixel bit.
REQ-012 pixel_valid  out  1  pixel holds valid data.
REQ-013 busy  out  1  readout in progress.
REQ-014 row_done  out  1  one-cycle pulse after the last pixel of a row is accepted.

Function
REQ-015 The FSM SHALL have four states: IDLE, READ, WAIT, SHIFT.
REQ-016 In IDLE, row_request=1 SHALL latch row_index into ram_address, drive read_enable=1 next cycle, and enter READ.
REQ-017 READ SHALL last exactly one cycle with read_enable=1, then enter WAIT.
REQ-018 WAIT SHALL count RAM_LATENCY cycles from the read_enable cycle, then load ram_q into a ROW_WIDTH shift register and enter SHIFT.
REQ-019 In SHIFT, pixel SHALL equal shift register bit ROW_WIDTH-1; bit ROW_WIDTH-1 of the RAM word is the leftmost pixel.
REQ-020 pixel_valid SHALL be 1 only in SHIFT.
REQ-021 A transfer SHALL occur when pixel_valid and pixel_ready are both 1; the register then shifts left by one and a 9-bit pixel counter increments.
REQ-022 While pixel_ready=0, pixel and the counter SHALL hold.
REQ-023 On the transfer with counter = ROW_WIDTH-1, the FSM SHALL go to IDLE, the counter SHALL clear, and row_done SHALL pulse for exactly the next cycle.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 row_request while busy=1 SHALL be ignored, with no queueing.
REQ-026 row_request in the same cycle as the row_done pulse SHALL be accepted, since the FSM is in IDLE.
REQ-027 read_enable SHALL be 0 outside READ; ram_address SHALL hold its last latched value.
REQ-028 First-pixel latency SHALL be 2+RAM_LATENCY clocks from the row_request cycle to the first cycle with pixel_valid=1.
REQ-029 With pixel_ready held at 1, a row SHALL complete in ROW_WIDTH consecutive cycles.

Reset
REQ-030 With rst_n=0 at a rising clk edge, the FSM SHALL go to IDLE, with counter=0, shift register=0, ram_address=0, read_enable=0, pixel=0, pixel_valid=0, busy=0, row_done=0.
REQ-031 Reset mid-row SHALL abandon the row without a row_done pulse.
REQ-032 A row_request in the same cycle as rst_n=0 SHALL be ignored.

Structure
REQ-033 The FSM state encoding and the ROW_WIDTH/ADDR_WIDTH defaults SHALL live in the shared package vga_adapter_pkg, which capture_ram_interface also uses.
REQ-034 The shift register and counter SHALL be one sub-module, row_shifter, with ports for load, shift enable, parallel in, serial out, and last.
REQ-035 The FSM, address latch and latency counter SHALL stay in capture_ram_reader.

Verification
REQ-036 Row with ram_q = 320'h8000...0001 at address 5 (row_index=5, pixel_ready=1): ram_address=5, read_enable for 1 cycle, first pixel valid 3 cycles after request; pixel=1 on transfer 0 and transfer 319, 0 otherwise; row_done 1 cycle after transfer 319.
REQ-037 Backpressure: pixel_ready=0 for 10 cycles after transfer 100: pixel and counter frozen; row completes after 330 cycles of SHIFT.
REQ-038 row_request asserted during SHIFT with row_index=9: ram_address stays unchanged, no extra read_enable, current row completes normally.
REQ-039 Back-to-back rows: row_request in the row_done cycle: the next read_enable follows 1 cycle later with no lost request.
REQ-040 rst_n=0 at transfer 150: all outputs at reset values next cycle, no row_done; a new request afterwards reads the full 320 pixels from bit 319.
REQ-041 Parameter sweep with RAM_LATENCY=2 and 3: first-pixel latency is 4 and 5 cycles; pixel data is correct.

Source files
------------

// File: rtl/vga_adapter_pkg.sv
// rtl/vga_adapter_pkg.sv - shared state encoding and geometry defaults for the capture RAM path
package vga_adapter_pkg;

    localparam int DEFAULT_ROW_WIDTH  = 320;
    localparam int DEFAULT_ADDR_WIDTH = 8;
    localparam int MAX_RAM_LATENCY    = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_SHIFT = 2'd3
    } reader_state_t;

    // Width of a counter that indexes every pixel of a row (9 bits for 320 pixels)
    function automatic int count_width(input int row_width);
        return (row_width <= 2) ? 1 : $clog2(row_width);
    endfunction

endpackage

// File: rtl/row_shifter.sv
// rtl/row_shifter.sv - row shift register with pixel counter, MSB-first serial output
module row_shifter
    import vga_adapter_pkg::*;
#(
    parameter int ROW_WIDTH   = DEFAULT_ROW_WIDTH,
    parameter int COUNT_WIDTH = count_width(ROW_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 shift_en,
    input  logic [ROW_WIDTH-1:0] parallel_in,
    output logic                 serial_out,
    output logic                 last
);

    localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(ROW_WIDTH - 1);

    logic [ROW_WIDTH-1:0]   shift_reg;
    logic [COUNT_WIDTH-1:0] count;

    // Load a fresh row, or shift one pixel out per accepted transfer; the counter wraps on the last pixel
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_reg <= '0;
            count     <= '0;
        end else if (load) begin
            shift_reg <= parallel_in;
            count     <= '0;
        end else if (shift_en) begin
            shift_reg <= {shift_reg[ROW_WIDTH-2:0], 1'b0};
            count     <= last ? '0 : count + 1'b1;
        end
    end

    assign serial_out = shift_reg[ROW_WIDTH-1];
    assign last       = (count == LAST_COUNT);

endmodule

// File: rtl/capture_ram_reader.sv
// rtl/capture_ram_reader.sv - reads one capture RAM row and streams it out pixel by pixel
module capture_ram_reader
    import vga_adapter_pkg::*;
#(
    parameter int ROW_WIDTH   = DEFAULT_ROW_WIDTH,
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int RAM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  row_request,
    input  logic [ADDR_WIDTH-1:0] row_index,
    input  logic [ROW_WIDTH-1:0]  ram_q,
    input  logic                  pixel_ready,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic                  read_enable,
    output logic                  pixel,
    output logic                  pixel_valid,
    output logic                  busy,
    output logic                  row_done
);

    // wait_count starts at 1 in the first WAIT cycle, which is RAM_LATENCY=1 clocks after read_enable
    localparam logic [1:0] LAST_WAIT = 2'(RAM_LATENCY);

    reader_state_t state;
    logic [1:0]    wait_count;
    logic          load;
    logic          transfer;
    logic          last;

    assign transfer = pixel_valid & pixel_ready;
    assign load     = (state == ST_WAIT) && (wait_count == LAST_WAIT);

    // Row readout sequencer: request -> one read strobe -> RAM latency wait -> pixel stream
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            wait_count  <= 2'd0;
            ram_address <= '0;
            read_enable <= 1'b0;
            pixel_valid <= 1'b0;
            busy        <= 1'b0;
            row_done    <= 1'b0;
        end else begin
            row_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (row_request) begin
                        ram_address <= row_index;
                        read_enable <= 1'b1;
                        busy        <= 1'b1;
                        state       <= ST_READ;
                    end
                end
                ST_READ: begin
                    read_enable <= 1'b0;
                    wait_count  <= 2'd1;
                    state       <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_count == LAST_WAIT) begin
                        pixel_valid <= 1'b1;
                        state       <= ST_SHIFT;
                    end else begin
                        wait_count <= wait_count + 2'd1;
                    end
                end
                ST_SHIFT: begin
                    if (transfer && last) begin
                        pixel_valid <= 1'b0;
                        busy        <= 1'b0;
                        row_done    <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    row_shifter #(
        .ROW_WIDTH (ROW_WIDTH)
    ) u_row_shifter (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .shift_en    (transfer),
        .parallel_in (ram_q),
        .serial_out  (pixel),
        .last        (last)
    );

endmodule

// File: tb/tb_capture_ram_reader.sv
// tb/tb_capture_ram_reader.sv - self-checking bench for capture_ram_reader at RAM latencies 1, 2 and 3
module tb_capture_ram_reader;

    localparam int RW = 320;
    localparam int AW = 8;
    localparam int NV = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          row_request;
    logic [AW-1:0] row_index;
    logic          pixel_ready;

    logic [RW-1:0] ram_q       [3];
    logic [AW-1:0] ram_address [3];
    logic          read_enable [3];
    logic          pixel       [3];
    logic          pixel_valid [3];
    logic          busy        [3];
    logic          row_done    [3];

    capture_ram_reader #(.ROW_WIDTH(RW), .ADDR_WIDTH(AW), .RAM_LATENCY(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .row_request(row_request), .row_index(row_index),
        .ram_q(ram_q[0]), .pixel_ready(pixel_ready), .ram_address(ram_address[0]),
        .read_enable(read_enable[0]), .pixel(pixel[0]), .pixel_valid(pixel_valid[0]),
        .busy(busy[0]), .row_done(row_done[0]));

    capture_ram_reader #(.ROW_WIDTH(RW), .ADDR_WIDTH(AW), .RAM_LATENCY(2)) u_l2 (
        .clk(clk), .rst_n(rst_n), .row_request(row_request), .row_index(row_index),
        .ram_q(ram_q[1]), .pixel_ready(pixel_ready), .ram_address(ram_address[1]),
        .read_enable(read_enable[1]), .pixel(pixel[1]), .pixel_valid(pixel_valid[1]),
        .busy(busy[1]), .row_done(row_done[1]));

    capture_ram_reader #(.ROW_WIDTH(RW), .ADDR_WIDTH(AW), .RAM_LATENCY(3)) u_l3 (
        .clk(clk), .rst_n(rst_n), .row_request(row_request), .row_index(row_index),
        .ram_q(ram_q[2]), .pixel_ready(pixel_ready), .ram_address(ram_address[2]),
        .read_enable(read_enable[2]), .pixel(pixel[2]), .pixel_valid(pixel_valid[2]),
        .busy(busy[2]), .row_done(row_done[2]));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s dut%0d: got %0d expected %0d", name, d, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] rand_word();
        logic [RW-1:0] w;
        for (int i = 0; i < RW; i += 32) w[i +: 32] = $urandom;
        return w;
    endfunction

    // RAM models: data appears RAM_LATENCY clocks after the strobe; junk otherwise
    logic [RW-1:0] mem  [256];
    logic [RW-1:0] pipe [3][3];

    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            pipe[d][0] <= read_enable[d] ? mem[ram_address[d]] : rand_word();
            pipe[d][1] <= pipe[d][0];
            pipe[d][2] <= pipe[d][1];
        end
    end

    assign ram_q[0] = pipe[0][0];
    assign ram_q[1] = pipe[1][1];
    assign ram_q[2] = pipe[2][2];

    // Reference model: cycle arithmetic from the request time plus a pixel index per DUT
    int            samp     = 0;
    int            req_samp = 0;
    bit            armed    = 1'b0;
    bit            m_busy   [3];
    int            m_start  [3];
    int            m_n      [3];
    int            m_done_c [3];
    logic [AW-1:0] m_addr   [3];
    logic [RW-1:0] m_word   [3];
    int            lat_obs  [3];
    logic          prev_pv  [3];

    task automatic model_step();
        samp++;
        for (int d = 0; d < 3; d++) begin
            automatic int lat      = d + 1;
            automatic bit cur_busy = m_busy[d];
            automatic bit e_re     = cur_busy && (samp == m_start[d] + 1);
            automatic bit e_pv     = cur_busy && (samp >= m_start[d] + 2 + lat);
            automatic bit e_pix    = e_pv ? m_word[d][RW-1-m_n[d]] : 1'b0;
            automatic bit e_done   = (samp == m_done_c[d] + 1);
            if (armed) begin
                check("busy",        d, 64'(busy[d]),        64'(cur_busy));
                check("read_enable", d, 64'(read_enable[d]), 64'(e_re));
                check("pixel_valid", d, 64'(pixel_valid[d]), 64'(e_pv));
                check("pixel",       d, 64'(pixel[d]),       64'(e_pix));
                check("row_done",    d, 64'(row_done[d]),    64'(e_done));
                check("ram_address", d, 64'(ram_address[d]), 64'(m_addr[d]));
            end
            if (pixel_valid[d] === 1'b1 && prev_pv[d] !== 1'b1) lat_obs[d] = samp - req_samp;
            prev_pv[d] = pixel_valid[d];
            if (!rst_n) begin
                m_busy[d]   = 1'b0;
                m_addr[d]   = '0;
                m_done_c[d] = -100;
            end else if (e_pv && pixel_ready) begin
                m_n[d]++;
                if (m_n[d] == RW) begin
                    m_busy[d]   = 1'b0;
                    m_done_c[d] = samp;
                end
            end else if (!cur_busy && row_request) begin
                m_busy[d]  = 1'b1;
                m_start[d] = samp;
                m_n[d]     = 0;
                m_addr[d]  = row_index;
                m_word[d]  = mem[row_index];
            end
        end
        if (!rst_n) armed = 1'b1;
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            m_busy[d] = 1'b0; m_start[d] = 0; m_n[d] = 0; m_done_c[d] = -100;
            m_addr[d] = '0; m_word[d] = '0; lat_obs[d] = 0; prev_pv[d] = 1'b0;
        end
        forever begin
            @(negedge clk);
            model_step();
        end
    end

    typedef struct {
        int row;
        int stall_after;
        int stall_len;
        int req_at;
        int rst_at;
        bit b2b;
        int b2b_row;
        bit rand_ready;
        int exp_shift;
        int exp_re;
        int exp_done;
        int exp_addr;
    } vec_t;

    vec_t vecs [NV];

    task automatic run_vec(input vec_t v);
        int  x0 = 0, stall_left = v.stall_len, re_cnt = 0, shift_cyc = 0, done_cnt = 0, rst_k = 0;
        bit  second = 1'b0, rst_done = 1'b0;
        int  want_done = v.b2b ? 2 : 1;
        @(posedge clk); #1;
        row_request = 1'b1; row_index = AW'(v.row); req_samp = samp + 1;
        @(posedge clk); #1;
        row_request = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (read_enable[0]) re_cnt++;
            if (pixel_valid[0]) shift_cyc++;
            if (pixel_valid[0] && pixel_ready) x0++;
            if (row_done[0]) done_cnt++;
            if (done_cnt >= want_done) break;
            if (rst_done && k > rst_k + 4) break;
            @(posedge clk); #1;
            row_request = 1'b0;
            rst_n       = 1'b1;
            if (v.rand_ready) pixel_ready = ($urandom_range(0, 3) != 0);
            else if (x0 == v.stall_after + 1 && stall_left > 0) begin
                pixel_ready = 1'b0;
                stall_left--;
            end else pixel_ready = 1'b1;
            if (v.req_at > 0 && k == v.req_at) begin
                row_request = 1'b1; row_index = AW'(9);
            end
            if (x0 == v.rst_at && !rst_done) begin
                rst_n = 1'b0; row_request = 1'b1; row_index = AW'(v.row + 1);
                rst_done = 1'b1; rst_k = k;
            end
            if (v.b2b && row_done[0] && !second) begin
                row_request = 1'b1; row_index = AW'(v.b2b_row);
                second = 1'b1; req_samp = samp + 1;
            end
        end
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            row_request = 1'b0; pixel_ready = 1'b1; rst_n = 1'b1;
            if (!busy[0] && !busy[1] && !busy[2]) break;
        end
        check("drain_idle", 0, 64'(busy[0] + busy[1] + busy[2]), 64'd0);
        if (v.exp_shift != 0) check("shift_cycles", 0, 64'(shift_cyc), 64'(v.exp_shift));
        check("read_strobes", 0, 64'(re_cnt), 64'(v.exp_re));
        check("row_done_count", 0, 64'(done_cnt), 64'(v.exp_done));
        check("final_address", 0, 64'(ram_address[0]), 64'(v.exp_addr));
        for (int d = 0; d < 3; d++) check("first_pixel_latency", d, 64'(lat_obs[d]), 64'(3 + d));
    endtask

    initial begin
        logic [RW-1:0] w5;
        int r;
        w5 = '0; w5[RW-1] = 1'b1; w5[0] = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = rand_word();
        mem[5] = w5;

        //         row sa   sl  rq  rst  b2b b2r rnd shift re dn addr
        vecs[0] = '{5,  -1, 0,  0,  -1,  0,  0,  0,  320,  1, 1, 5};
        vecs[1] = '{17, 100,10, 0,  -1,  0,  0,  0,  330,  1, 1, 17};
        vecs[2] = '{33, -1, 0,  50, -1,  0,  0,  0,  320,  1, 1, 33};
        vecs[3] = '{40, -1, 0,  0,  -1,  1,  41, 0,  640,  2, 2, 41};
        vecs[4] = '{60, -1, 0,  0,  150, 0,  0,  0,  151,  1, 0, 0};
        vecs[5] = '{61, -1, 0,  0,  -1,  0,  0,  0,  320,  1, 1, 61};
        for (int i = 6; i < NV; i++) begin
            r = $urandom_range(0, 255);
            vecs[i] = '{r, -1, 0, 0, -1, 0, 0, 1, 0, 1, 1, r};
        end

        rst_n = 1'b0; row_request = 1'b1; row_index = AW'(7); pixel_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1; row_request = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < NV; i++) run_vec(vecs[i]);

        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
